// File: rtl/debug_uart_rx.sv
// Debug-port 8N1 UART receiver: pin mux, resynchroniser, 16x oversample tick
// from the autobaud divisor, deframer FSM and a valid/ready holding register.
module debug_uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_wr,
  input  logic [7:0]           baud_div,
  input  logic [1:0]           rx_sel,
  input  logic                 rx1,
  input  logic                 rx2,
  input  logic                 rx3,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CNT_W  = DIV_W + 1;
  localparam int unsigned TCNT_W = 4;
  localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_n;
  logic                   pin_c;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srx, srx_d;
  logic [DIV_W-1:0]       div_reg;
  logic [CNT_W-1:0]       cnt_q, term_c;
  logic                   div_zero_c, tick_c;
  logic [TCNT_W-1:0]      tcnt_q;
  logic [BCNT_W-1:0]      bcnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   deliver_q;
  logic                   clr_c, start_ok_c, sample_c, stop_ok_c, stop_bad_c;

  // Pin select; an unselected line idles high
  always_comb begin
    case (rx_sel)
      2'd1:    pin_c = rx1;
      2'd2:    pin_c = rx2;
      2'd3:    pin_c = rx3;
      default: pin_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      srx_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_c};
      srx_d  <= srx;
    end
  end

  assign srx = sync_q[SYNC_STAGES-1];

  // Oversample tick: one pulse every 2*div_reg clocks
  assign div_zero_c = (div_reg == '0);
  assign term_c     = {div_reg, 1'b0} - CNT_W'(1);
  assign tick_c     = !div_zero_c && !baud_wr && (cnt_q == term_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      cnt_q   <= '0;
    end else begin
      if (baud_wr) div_reg <= baud_div;
      if (baud_wr || clr_c || div_zero_c || cnt_q == term_c) cnt_q <= '0;
      else                                                    cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Next state and datapath strobes; a divisor write aborts any frame
  always_comb begin
    state_n    = state_q;
    clr_c      = 1'b0;
    start_ok_c = 1'b0;
    sample_c   = 1'b0;
    stop_ok_c  = 1'b0;
    stop_bad_c = 1'b0;
    if (baud_wr || div_zero_c) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (srx_d && !srx) begin
            clr_c   = 1'b1;
            state_n = S_START;
          end
        end
        S_START: begin
          if (tick_c && tcnt_q == TCNT_W'(7)) begin
            if (srx) begin
              state_n = S_IDLE;
            end else begin
              start_ok_c = 1'b1;
              state_n    = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick_c && tcnt_q == '1) begin
            sample_c = 1'b1;
            if (bcnt_q == BCNT_W'(DATA_BITS - 1)) state_n = S_STOP;
          end
        end
        S_STOP: begin
          if (tick_c && tcnt_q == '1) begin
            if (srx) begin
              stop_ok_c = 1'b1;
              state_n   = S_IDLE;
            end else begin
              stop_bad_c = 1'b1;
              state_n    = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (srx) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Tick/bit counters and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      deliver_q <= 1'b0;
    end else begin
      if (clr_c || start_ok_c) tcnt_q <= '0;
      else if (tick_c)         tcnt_q <= tcnt_q + TCNT_W'(1);
      if (start_ok_c)    bcnt_q <= '0;
      else if (sample_c) bcnt_q <= bcnt_q + BCNT_W'(1);
      if (sample_c) shift_q <= {srx, shift_q[DATA_BITS-1:1]};
      deliver_q <= stop_ok_c;
    end
  end

  // Holding register and sticky flags; a set event beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (deliver_q && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (deliver_q && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (err_clr)                       overrun <= 1'b0;
      if (stop_bad_c)   frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      busy <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx: vector table, directed corner cases
// and randomized frames checked against a byte-level holding-register model.
module tb_debug_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_wr;
  logic [7:0] baud_div;
  logic [1:0] rx_sel;
  logic       rx1, rx2, rx3;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err_clr;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  debug_uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .baud_wr(baud_wr), .baud_div(baud_div),
    .rx_sel(rx_sel), .rx1(rx1), .rx2(rx2), .rx3(rx3),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_clr(err_clr), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;

  // Reference model of the consumer-visible state
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;

  typedef struct {
    int         sel;
    logic [7:0] div;
    logic [7:0] data;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pin(input int p, input logic v);
    case (p)
      1: rx1 = v;
      2: rx2 = v;
      3: rx3 = v;
      default: ;
    endcase
  endtask

  task automatic set_baud(input logic [7:0] d);
    baud_wr = 1'b1; baud_div = d;
    wait_clks(1);
    baud_wr = 1'b0;
    wait_clks(1);
  endtask

  task automatic send_bits(input int p, input logic [7:0] b, input int bc);
    set_pin(p, 1'b0);
    start_cyc = cyc;
    wait_clks(bc);
    for (int i = 0; i < 8; i++) begin
      set_pin(p, b[i]);
      wait_clks(bc);
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] b, input int bc);
    send_bits(p, b, bc);
    set_pin(p, 1'b1);
    wait_clks(bc);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic rdy);
    if (rdy) begin
      m_data = b; m_valid = 1'b0;
    end else if (m_valid) begin
      m_ovr = 1'b1;
    end else begin
      m_data = b; m_valid = 1'b1;
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(1);
    m_valid = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
    wait_clks(1);
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    check({tag, ".busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic dropped;
    logic done;
    int   t;
    logic seen_busy;

    rst_n = 1'b0; baud_wr = 1'b0; baud_div = 8'd0; rx_sel = 2'd0;
    rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;

    vecs[0] = '{sel: 2, div: 8'd4, data: 8'hA5, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'hA5};
    vecs[1] = '{sel: 1, div: 8'd4, data: 8'h00, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'h00};
    vecs[2] = '{sel: 3, div: 8'd4, data: 8'hFF, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'hFF};
    vecs[3] = '{sel: 1, div: 8'd2, data: 8'h81, ready: 1'b1, exp_valid: 1'b0, exp_data: 8'h81};
    vecs[4] = '{sel: 3, div: 8'd3, data: 8'h5A, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'h5A};
    vecs[5] = '{sel: 2, div: 8'd2, data: 8'hC3, ready: 1'b1, exp_valid: 1'b0, exp_data: 8'hC3};

    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(1);
    check_all("reset");

    // Divisor zero: start edges ignored
    rx_sel = 2'd1;
    rx1 = 1'b0;
    wait_clks(100);
    check("div0.busy", 32'(busy), 32'(0));
    rx1 = 1'b1;
    wait_clks(20);
    check_all("div0");

    // Vector table
    foreach (vecs[k]) begin
      set_baud(vecs[k].div);
      rx_sel = 2'(vecs[k].sel);
      rx_ready = vecs[k].ready;
      rise_cyc = -1;
      send_frame(vecs[k].sel, vecs[k].data, 32 * int'(vecs[k].div));
      rx_ready = 1'b0;
      check($sformatf("vec%0d.valid", k), 32'(rx_valid), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d.data", k), 32'(rx_data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d.frame_err", k), 32'(frame_err), 32'(0));
      check($sformatf("vec%0d.overrun", k), 32'(overrun), 32'(0));
      if (k == 0)
        check("vec0.latency_ok", 32'((rise_cyc - start_cyc) >= 1214 && (rise_cyc - start_cyc) <= 1226), 32'(1));
      model_frame(vecs[k].data, vecs[k].ready);
      consume();
    end

    // Back-to-back frames with no consumer -> overrun
    set_baud(8'd4);
    rx_sel = 2'd2;
    send_frame(2, 8'h3C, 128);
    model_frame(8'h3C, 1'b0);
    send_frame(2, 8'h7E, 128);
    model_frame(8'h7E, 1'b0);
    check_all("b2b");
    clear_errs();
    check("b2b.ovr_clr", 32'(overrun), 32'(0));
    consume();

    // 40-clock glitch is a false start
    rx_sel = 2'd1;
    rx1 = 1'b0;
    wait_clks(40);
    rx1 = 1'b1;
    wait_clks(10);
    check("glitch.busy_mid", 32'(busy), 32'(1));
    wait_clks(25);
    check("glitch.busy_end", 32'(busy), 32'(0));
    check_all("glitch");

    // Stop bit held low for 3 bit times -> frame error and break
    rx_sel = 2'd3;
    send_bits(3, 8'h55, 128);
    rx3 = 1'b0;
    wait_clks(3 * 128);
    check("brk.frame_err", 32'(frame_err), 32'(1));
    check("brk.valid", 32'(rx_valid), 32'(0));
    check("brk.busy", 32'(busy), 32'(1));
    rx3 = 1'b1;
    wait_clks(10);
    m_ferr = 1'b1;
    check_all("brk.release");
    send_frame(3, 8'h12, 128);
    model_frame(8'h12, 1'b0);
    check_all("brk.next");
    clear_errs();
    check("brk.ferr_clr", 32'(frame_err), 32'(0));

    // Accept in the same cycle as the next byte loads
    rx_sel = 2'd2;
    dropped = 1'b0;
    done = 1'b0;
    fork
      send_frame(2, 8'hC6, 128);
      begin
        t = 0;
        seen_busy = 1'b0;
        while (!done && t < 3000) begin
          @(negedge clk);
          t++;
          if (!rx_valid) dropped = 1'b1;
          if (busy) seen_busy = 1'b1;
          else if (seen_busy) begin
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            done = 1'b1;
          end
        end
      end
    join
    check("sim.done", 32'(done), 32'(1));
    check("sim.no_drop", 32'(dropped), 32'(0));
    m_data = 8'hC6; m_valid = 1'b1;
    check_all("sim");
    consume();

    // Divisor write mid-DATA aborts the frame
    set_baud(8'd4);
    rx_sel = 2'd2;
    rx2 = 1'b0;
    wait_clks(128);
    rx2 = 1'b1;
    wait_clks(3 * 128);
    baud_wr = 1'b1; baud_div = 8'd8;
    wait_clks(1);
    baud_wr = 1'b0;
    wait_clks(1);
    check("abort.busy", 32'(busy), 32'(0));
    wait_clks(2000);
    check_all("abort");
    send_frame(2, 8'h96, 256);
    model_frame(8'h96, 1'b0);
    check_all("abort.div8");

    // Randomized frames against the model
    for (int r = 0; r < 10; r++) begin
      logic [7:0] b;
      int         sel;
      logic [7:0] d;
      logic       rdy;
      b   = 8'($urandom);
      sel = int'($urandom_range(1, 3));
      d   = 8'($urandom_range(2, 4));
      rdy = 1'($urandom_range(0, 1));
      set_baud(d);
      rx_sel = 2'(sel);
      rx_ready = rdy;
      send_frame(sel, b, 32 * int'(d));
      rx_ready = 1'b0;
      model_frame(b, rdy);
      check_all($sformatf("rnd%0d", r));
      if ($urandom_range(0, 2) == 0) clear_errs();
      if ($urandom_range(0, 1) == 0) consume();
    end

    // Async reset mid-frame with a pending byte
    set_baud(8'd8);
    rx_sel = 2'd1;
    send_frame(1, 8'hE7, 256);
    model_frame(8'hE7, 1'b0);
    rx1 = 1'b0;
    wait_clks(3 * 256);
    rst_n = 1'b0;
    #1;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    check_all("rst");
    rx1 = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2);
    set_baud(8'd8);
    send_frame(1, 8'h4B, 256);
    model_frame(8'h4B, 1'b0);
    check_all("rst.next");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
